// File: rtl/sao_lcu_feeder_if.sv
// sao_lcu_feeder_if
// Groups the three buses around the SAO feeder:
//   image SRAM   : img_rd, img_addr -> ; <- img_q (1-cycle read latency)
//   param ROM    : par_rd, par_addr -> ; <- par_q (1-cycle read latency)
//   SAO stream   : in_en, din, sao_*, lcu_x, lcu_y, lcu_size -> ; <- busy
// master = feeder side, slave = memories/SAO side.
interface sao_lcu_feeder_if #(
    parameter int AW = 14
);
    logic          img_rd;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_q;
    logic          par_rd;
    logic [5:0]    par_addr;
    logic [23:0]   par_q;
    logic          busy;
    logic          in_en;
    logic [7:0]    din;
    logic [1:0]    sao_type;
    logic [4:0]    sao_band_pos;
    logic          sao_eo_class;
    logic [15:0]   sao_offset;
    logic [2:0]    lcu_x;
    logic [2:0]    lcu_y;
    logic [1:0]    lcu_size;

    modport master (
        output img_rd, img_addr, par_rd, par_addr,
        output in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
        output lcu_x, lcu_y, lcu_size,
        input  img_q, par_q, busy
    );

    modport slave (
        input  img_rd, img_addr, par_rd, par_addr,
        input  in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset,
        input  lcu_x, lcu_y, lcu_size,
        output img_q, par_q, busy
    );
endinterface

// File: rtl/sao_lcu_feeder.sv
// sao_lcu_feeder
// Reads a raster-ordered IMG_W x IMG_W 8-bit frame from the image SRAM and
// re-orders it into LCU-major, row-major-within-LCU order for the SAO stage,
// fetching each LCU's parameters from the parameter ROM before its pixels.
// Ports:
//   clk, reset    : clock (rising edge), asynchronous active-high reset
//   start         : 1-cycle pulse, begins a frame (ignored while active)
//   lcu_size_i    : 0=16x16, 1=32x32, 2/3=64x64, latched at start
//   active, done  : frame in progress / frame finished (level)
//   bus (master)  : image SRAM, parameter ROM and SAO stream signals
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | waiting for start
// PARAM_RD  | par_rd asserted with par_addr = n
// PARAM_CAP | par_q captured into sao_*, lcu_x/lcu_y updated
// STREAM    | issuing image reads for the current LCU
// DRAIN     | waiting for the LCU's last beat to be accepted
// DONE      | frame finished, returns to IDLE (start accepted here too)
module sao_lcu_feeder #(
    parameter int IMG_W = 128,
    parameter int AW    = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] lcu_size_i,
    output logic       active,
    output logic       done,
    sao_lcu_feeder_if.master bus
);
    localparam int CW = $clog2(IMG_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARAM_RD,
        ST_PARAM_CAP,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [5:0]    n;
    logic [5:0]    px, py;
    logic [1:0]    lcu_size_q;
    logic [2:0]    lcu_x_q, lcu_y_q;
    logic [1:0]    type_q;
    logic [4:0]    band_q;
    logic          eo_q;
    logic [15:0]   offset_q;

    logic [2:0]    lg;
    logic [5:0]    s_max;
    logic [5:0]    n_max;
    logic [2:0]    x_mask;
    logic [1:0]    y_shift;

    logic [7:0]    fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          inflight;

    logic          pop, room;
    logic          start_ok, drain_ok, last_read;
    logic [CW-1:0] row, col;

    // Geometry from the latched size: log2(S), S-1, N*N-1, and how to split n
    // into (lcu_x, lcu_y). Size 3 is handled as 64x64.
    always_comb begin
        case (lcu_size_q)
            2'd0: begin
                lg = 3'd4; s_max = 6'd15; n_max = 6'd63; x_mask = 3'd7; y_shift = 2'd3;
            end
            2'd1: begin
                lg = 3'd5; s_max = 6'd31; n_max = 6'd15; x_mask = 3'd3; y_shift = 2'd2;
            end
            default: begin
                lg = 3'd6; s_max = 6'd63; n_max = 6'd3; x_mask = 3'd1; y_shift = 2'd1;
            end
        endcase
    end

    assign row          = (CW'(lcu_y_q) << lg) + CW'(py);
    assign col          = (CW'(lcu_x_q) << lg) + CW'(px);
    assign bus.img_addr = AW'(row) * AW'(IMG_W) + AW'(col);
    assign bus.par_addr = n;

    assign bus.in_en        = (count != 2'd0);
    assign bus.din          = fifo_mem[rd_ptr];
    assign bus.sao_type     = type_q;
    assign bus.sao_band_pos = band_q;
    assign bus.sao_eo_class = eo_q;
    assign bus.sao_offset   = offset_q;
    assign bus.lcu_x        = lcu_x_q;
    assign bus.lcu_y        = lcu_y_q;
    assign bus.lcu_size     = lcu_size_q;

    assign pop = bus.in_en & ~bus.busy;
    // Reads in flight land in the FIFO next cycle; the pop this cycle frees a
    // slot early, which is what keeps one beat per clock when busy is low.
    assign room = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bus.img_rd = 1'b0;
        bus.par_rd = 1'b0;
        start_ok   = 1'b0;
        drain_ok   = 1'b0;
        last_read  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_PARAM_RD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PARAM_RD: begin
                bus.par_rd = 1'b1;
                state_nxt  = ST_PARAM_CAP;
            end
            ST_PARAM_CAP: begin
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                bus.img_rd = room;
                last_read  = room && (px == s_max) && (py == s_max);
                if (last_read) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that accepts the LCU's last beat.
                drain_ok = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));
                if (drain_ok) begin
                    state_nxt = (n == n_max) ? ST_DONE : ST_PARAM_RD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active      <= 1'b0;
            done        <= 1'b0;
            n           <= '0;
            px          <= '0;
            py          <= '0;
            lcu_size_q  <= '0;
            lcu_x_q     <= '0;
            lcu_y_q     <= '0;
            type_q      <= '0;
            band_q      <= '0;
            eo_q        <= 1'b0;
            offset_q    <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= bus.img_rd;
            if (inflight) begin
                fifo_mem[wr_ptr] <= bus.img_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};

            if (start_ok) begin
                active     <= 1'b1;
                done       <= 1'b0;
                lcu_size_q <= lcu_size_i;
                n          <= '0;
                px         <= '0;
                py         <= '0;
            end

            if (state == ST_PARAM_CAP) begin
                type_q   <= bus.par_q[23:22];
                band_q   <= bus.par_q[21:17];
                eo_q     <= bus.par_q[16];
                offset_q <= bus.par_q[15:0];
                lcu_x_q  <= n[2:0] & x_mask;
                lcu_y_q  <= 3'(n >> y_shift);
            end

            if (bus.img_rd) begin
                if (px == s_max) begin
                    px <= '0;
                    py <= (py == s_max) ? 6'd0 : py + 6'd1;
                end else begin
                    px <= px + 6'd1;
                end
            end

            if (drain_ok) begin
                if (n == n_max) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    n <= n + 6'd1;
                end
            end
        end
    end
endmodule

// File: doc/sao_lcu_feeder.md
Name: sao_lcu_feeder

Overview:
- Upstream stage of the SAO filter.
- Reads a raster-ordered 128x128 8-bit frame from the image SRAM and the per-LCU parameter ROM.
- Re-orders pixels into LCU-major / row-major-within-LCU order and streams them to SAO.
- Drives SAO's din/in_en/sao_*/lcu_x/lcu_y/lcu_size and honours SAO's busy backpressure.

Parameters:
- IMG_W, 128, frame width and height in pixels.
- AW, 14, image SRAM address width (log2(IMG_W*IMG_W)).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins one frame; ignored while active=1.
- lcu_size_i  in  2  0=16x16, 1=32x32, 2=64x64, 3 treated as 64x64; latched at start.
- img_rd  out  1  image SRAM read enable.
- img_addr  out  AW  image SRAM address = row*IMG_W+col.
- img_q  in  8  read data, valid exactly 1 cycle after img_rd.
- par_rd  out  1  parameter ROM read enable.
- par_addr  out  6  parameter ROM address = raster LCU index n.
- par_q  in  24  [23:22] type, [21:17] band_pos, [16] eo_class, [15:0] offset; 1-cycle latency.
- busy  in  1  from SAO; a beat transfers on a rising edge where in_en=1 and busy=0.
- in_en  out  1  beat valid.
- din  out  8  pixel.
- sao_type  out  2  current LCU parameters.
- sao_band_pos  out  5  current LCU parameters.
- sao_eo_class  out  1  current LCU parameters.
- sao_offset  out  16  current LCU parameters.
- lcu_x  out  3  current LCU column.
- lcu_y  out  3  current LCU row.
- lcu_size  out  2  latched lcu_size_i.
- active  out  1  frame in progress.
- done  out  1  level; set after last beat, cleared by next accepted start.

Behaviour:
Reset:
- Every output above is 0; FSM goes to IDLE; FIFO is emptied.
- Reset mid-frame abandons the frame. No resume. A new start restarts from pixel 0.

Geometry:
- S = 16/32/64; N = 128/S LCUs per row.
- LCU index n = lcu_y*N + lcu_x, visited in raster order 0..N*N-1.
- Within an LCU, pixel (py,px) is read at address (lcu_y*S+py)*IMG_W + lcu_x*S + px, px fastest.

FSM:
- IDLE: on start, latch lcu_size, set active=1, clear done, n=0 → PARAM.
- PARAM: cycle 1 asserts par_rd with par_addr=n. Cycle 2 captures par_q into the sao_* registers and updates lcu_x/lcu_y → STREAM.
- STREAM: issues image reads. After the S*S-th read of the LCU is issued → DRAIN.
- DRAIN: waits until the FIFO is empty and the last beat is accepted. Then → PARAM if n<N*N-1 (n increments), else → DONE.
- DONE: active=0, done=1 → IDLE.

Datapath / handshake:
- 2-entry output FIFO; din/in_en reflect the FIFO head.
- pop = in_en & ~busy.
- Issue img_rd in STREAM only when count + inflight - pop < 2. busy feeds img_rd combinationally, and this path is intended.
- With busy=0, beats are sustained 1 per clock inside an LCU.
- While busy=1: in_en and din hold stable; no beat is lost or duplicated; count never exceeds 2.
- sao_*, lcu_x and lcu_y change only in PARAM. They are therefore constant over all S*S beats of an LCU and already valid with the LCU's first beat.
- First beat of a new LCU has in_en=1 no later than 4 cycles after the previous LCU's last beat is accepted, when busy=0.
- First beat of the frame has in_en=1 within 5 cycles of start.
- Total beats per frame = 16384 exactly, for any lcu_size.

Test Plan:
- Ordering: lcu_size_i=1, busy=0, img[a]=a[7:0]. Beats 0,1,31,32 → din 00,01,1F,80 (addr 0,1,31,128). Beat 1024 → addr 32 with lcu_x=1, lcu_y=0. Beat 16383 → addr 16383. done rises the cycle after.
- Backpressure: busy=1 for 5 cycles starting at beat 100, then a random 30% busy pattern. Captured stream equals the busy=0 stream; in_en/din are stable while busy=1.
- Params: par[0]=24'h8A1234, par[1]=24'h432100. sao_type=2, band_pos=5, eo_class=0, offset=1234 for beats 0..1023. Values switch to type=1, band_pos=1, eo_class=1, offset=2100 coincident with beat 1024, and never mid-LCU.
- Small LCU: lcu_size_i=0. 64 LCUs; lcu_x sweeps 0..7 per row; beat 256 → addr 16. The final LCU has lcu_x=lcu_y=7; par_addr reaches 63.
- Reset mid-frame: assert reset at beat 500. All outputs are 0 immediately. After a new start, beat 0 → din=img[0], lcu_x=lcu_y=0.
- Start ignored and size 3: pulse start at beat 50 → no restart and 16384 beats total. lcu_size_i=3 → 4 LCUs of 4096 beats each.
